// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 timing constants, coordinate widths and sync bundle type for the VGA path.
// Every *_display block imports this package so that it uses the same X_W/Y_W widths.
package vga_sync_gen_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_PIX_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    // One extra bit so that lo+len == 2048 still compares correctly.
    function automatic logic in_window(input logic [X_W-1:0] v, input int lo, input int len);
        return ({1'b0, v} >= (X_W+1)'(lo)) && ({1'b0, v} < (X_W+1)'(lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel clock-enable divider: p_tick is a registered one-clk pulse every PIX_DIV clks.
// With PIX_DIV=1 the counter never leaves 0, so p_tick stays high after the first clk.
module pixel_tick_gen #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int CNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             p_tick_reg;

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg    <= '0;
            p_tick_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            p_tick_reg <= (cnt_reg == CNT_LAST);
        end
    end

    assign p_tick = p_tick_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing master: pixel counters, sync/visible decode and registered outputs.
// Optional VGA_SYNC_DELAY_EN adds one pixel of delay on hsync/vsync/video_on to match sprite ROM latency.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset_n,
    output logic           p_tick,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
    localparam sync_t SYNC_IDLE = '{hsync: !SYNC_POL, vsync: !SYNC_POL, video_on: 1'b0};

    logic           tick;
    logic [X_W-1:0] x_reg;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_reg;
    logic [Y_W-1:0] y_next;
    logic           wrap_next;
    logic           frame_start_reg;
    sync_t          sync_reg;
    sync_t          sync_next;
    sync_t          sync_out;

    pixel_tick_gen #(
        .PIX_DIV(PIX_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .p_tick (tick)
    );

    always_comb begin
        x_next    = x_reg;
        y_next    = y_reg;
        wrap_next = 1'b0;
        if (tick) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                if (y_reg == Y_LAST) begin
                    y_next    = '0;
                    wrap_next = 1'b1;
                end else begin
                    y_next = y_reg + Y_W'(1);
                end
            end else begin
                x_next = x_reg + X_W'(1);
            end
        end
    end

    // Decode from the next coordinate so the sync bundle lands in the same edge as x/y.
    always_comb begin
        sync_next.hsync    = in_window(x_next, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : !SYNC_POL;
        sync_next.vsync    = in_window(X_W'(y_next), V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : !SYNC_POL;
        sync_next.video_on = (x_next < X_W'(H_ACTIVE)) && (y_next < Y_W'(V_ACTIVE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            sync_reg        <= SYNC_IDLE;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            frame_start_reg <= wrap_next;
            if (tick) begin
                sync_reg <= sync_next;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    sync_t sync_dly_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_dly_reg <= SYNC_IDLE;
        end else if (tick) begin
            sync_dly_reg <= sync_reg;
        end
    end

    assign sync_out = sync_dly_reg;
`else
    assign sync_out = sync_reg;
`endif

    assign p_tick      = tick;
    assign x           = x_reg;
    assign y           = y_reg;
    assign hsync       = sync_out.hsync;
    assign vsync       = sync_out.vsync;
    assign video_on    = sync_out.video_on;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a reduced 30x15 raster (PIX_DIV=4) plus a PIX_DIV=1 instance.
// Expected values come from the edge count since reset release and the hand-chosen geometry.
module tb_vga_sync_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 4, HT = 30;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3, VT = 15;
    localparam int FR = HT * VT;
`ifdef VGA_SYNC_DELAY_EN
    localparam int HS_FIRST_X = 21;
    localparam int VO_FALL_X  = 17;
`else
    localparam int HS_FIRST_X = 20;
    localparam int VO_FALL_X  = 16;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        p_tick, hsync, vsync, video_on, frame_start;
    logic [10:0] x;
    logic [9:0]  y;
    logic        p_tick1, hsync1, vsync1, video_on1, frame_start1;
    logic [10:0] x1;
    logic [9:0]  y1;

    int e;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .PIX_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
    );

    vga_sync_gen #(
        .PIX_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick1), .x(x1), .y(y1),
        .hsync(hsync1), .vsync(vsync1), .video_on(video_on1), .frame_start(frame_start1)
    );

    // Counter updates completed after edge ec (PIX_DIV=4): p_tick high after edges 4,8,..; updates at 5,9,..
    function automatic int upd4(input int ec);
        return (ec >= 1) ? (ec - 1) / 4 : 0;
    endfunction

    // {hsync, vsync, video_on} of the undelayed stage after u updates.
    function automatic logic [2:0] dec(input int u);
        int px;
        int py;
        logic hs, vs, vo;
        if (u == 0) return 3'b110;
        px = u % HT;
        py = (u / HT) % VT;
        hs = !((px >= HA + HF) && (px < HA + HF + HS));
        vs = !((py >= VA + VF) && (py < VA + VF + VS));
        vo = (px < HA) && (py < VA);
        return {hs, vs, vo};
    endfunction

    // Full expected output vector {p_tick, x, y, hsync, vsync, video_on, frame_start}.
    function automatic logic [25:0] exp_vec(input int ec);
        int u;
        logic [2:0] s;
        logic pt, fs;
        u = upd4(ec);
`ifdef VGA_SYNC_DELAY_EN
        s = (u == 0) ? 3'b110 : dec(u - 1);
`else
        s = dec(u);
`endif
        pt = (ec >= 4) && (ec % 4 == 0);
        fs = (ec >= 5) && ((ec - 1) % 4 == 0) && (u > 0) && (u % FR == 0);
        return {pt, 11'(u % HT), 10'((u / HT) % VT), s, fs};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        e = 0;
    endtask

    task automatic test_reset();
        logic [25:0] got;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {p_tick, x, y, hsync, vsync, video_on, frame_start};
        total++;
        if (got !== {1'b0, 11'd0, 10'd0, 3'b110, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", got, {1'b0, 11'd0, 10'd0, 3'b110, 1'b0});
        end
        total++;
        if (p_tick1 !== 1'b0 || x1 !== 11'd0) begin
            bad++;
            $display("FAIL reset_state_div1 p_tick=%b x=%0d want p_tick=0 x=0", p_tick1, x1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        e = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (p_tick !== ((i == 4) || (i == 8))) begin
                bad++;
                $display("FAIL p_tick_start clk=%0d got=%b want=%b", i, p_tick, (i == 4) || (i == 8));
            end
        end
        $display("reset: released, p_tick observed over 8 clks");
    endtask

    task automatic test_line();
        logic [25:0] got, want;
        int hs_low = 0;
        int hs_first = -1;
        int vo_fall = -1;
        logic vo_prev = 1'b0;
        while (e < 4 * (HT + 2) + 1) begin
            step();
            got  = {p_tick, x, y, hsync, vsync, video_on, frame_start};
            want = exp_vec(e);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL line_outputs clk=%0d got=%h want=%h", e, got, want);
            end
            if (e >= 5 && (e - 1) % 4 == 0) begin
                if (hsync === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(x);
                end
                if (vo_prev === 1'b1 && video_on === 1'b0 && vo_fall < 0) vo_fall = int'(x);
                vo_prev = video_on;
            end
        end
        total++;
        if (hs_low != HS) begin
            bad++;
            $display("FAIL hsync_width got=%0d want=%0d", hs_low, HS);
        end
        total++;
        if (hs_first != HS_FIRST_X) begin
            bad++;
            $display("FAIL hsync_first_x got=%0d want=%0d", hs_first, HS_FIRST_X);
        end
        total++;
        if (vo_fall != VO_FALL_X) begin
            bad++;
            $display("FAIL video_on_fall_x got=%0d want=%0d", vo_fall, VO_FALL_X);
        end
        $display("line: hsync_low_ticks=%0d first_x=%0d video_fall_x=%0d", hs_low, hs_first, vo_fall);
    endtask

    task automatic test_frame();
        logic [25:0] got, want;
        int vs_low = 0;
        int fs_first = -1;
        int fs_count = 0;
        while (e < 4 * (FR + 3) + 1) begin
            step();
            got  = {p_tick, x, y, hsync, vsync, video_on, frame_start};
            want = exp_vec(e);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL frame_outputs clk=%0d got=%h want=%h", e, got, want);
            end
            if (e >= 5 && (e - 1) % 4 == 0 && upd4(e) <= FR && vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) begin
                fs_count++;
                if (fs_first < 0) fs_first = e;
            end
        end
        total++;
        if (vs_low != VS * HT) begin
            bad++;
            $display("FAIL vsync_ticks got=%0d want=%0d", vs_low, VS * HT);
        end
        total++;
        if (fs_first != 4 * FR + 1 || fs_count != 1) begin
            bad++;
            $display("FAIL frame_start_pulse clk=%0d count=%0d want clk=%0d count=1", fs_first, fs_count, 4 * FR + 1);
        end
        $display("frame: vsync_low_ticks=%0d frame_start_clk=%0d", vs_low, fs_first);
    endtask

    task automatic test_async_reset();
        logic [25:0] got, want;
        while (e < 4 * (FR + 5 * HT + 10) + 1) begin
            step();
            got  = {p_tick, x, y, hsync, vsync, video_on, frame_start};
            want = exp_vec(e);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL pre_reset_outputs clk=%0d got=%h want=%h", e, got, want);
            end
        end
        total++;
        if (x !== 11'd10 || y !== 10'd5) begin
            bad++;
            $display("FAIL pre_reset_pos got=(%0d,%0d) want=(10,5)", x, y);
        end
        #1 reset_n = 1'b0;
        #1;
        got = {p_tick, x, y, hsync, vsync, video_on, frame_start};
        total++;
        if (got !== {1'b0, 11'd0, 10'd0, 3'b110, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", got, {1'b0, 11'd0, 10'd0, 3'b110, 1'b0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        e = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            got  = {p_tick, x, y, hsync, vsync, video_on, frame_start};
            want = exp_vec(e);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL restart_outputs clk=%0d got=%h want=%h", e, got, want);
            end
        end
        $display("async_reset: outputs cleared mid-frame, restart from (0,0)");
    endtask

    task automatic test_pixdiv1();
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step();
            total++;
            if (p_tick1 !== 1'b1 || x1 !== 11'((i - 1) % HT) || y1 !== 10'(((i - 1) / HT) % VT)) begin
                bad++;
                $display("FAIL div1_count clk=%0d got p_tick=%b x=%0d y=%0d want p_tick=1 x=%0d y=%0d",
                         i, p_tick1, x1, y1, (i - 1) % HT, ((i - 1) / HT) % VT);
            end
        end
        $display("pixdiv1: p_tick held high, x advanced every clk for 40 clks");
    endtask

    initial begin
        e = 0;
        test_reset();
        test_line();
        test_frame();
        test_async_reset();
        test_pixdiv1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
